// File: rtl/tune_sequencer_if.sv
// Play-request / tone-output bundle between a game-event source and the tune sequencer.
// The master side issues play requests; the slave side is the sequencer.
interface tune_sequencer_if;
  logic        play;
  logic [1:0]  tune_sel;
  logic [31:0] period;
  logic        audEn;
  logic        busy;
  logic        done;

  modport master (
    output play, tune_sel,
    input  period, audEn, busy, done
  );

  modport slave (
    input  play, tune_sel,
    output period, audEn, busy, done
  );
endinterface

// File: rtl/tune_sequencer.sv
// Steps through a fixed 4-tune ROM on a play request, driving the tone period and
// speaker enable for the downstream square-wave generator. All outputs are registered.
module tune_sequencer #(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned GAP_TICKS      = 10,
  parameter int unsigned NOTES_PER_TUNE = 8
) (
  input  logic              clock100,
  input  logic              reset_n,
  tune_sequencer_if.slave   bus
);

  localparam int unsigned IDXW = (NOTES_PER_TUNE > 1) ? $clog2(NOTES_PER_TUNE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NOTES_PER_TUNE - 1);
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS) - 32'd1;

  // Entry = {last, note[3:0], dur[6:0]}; tune t occupies entries 8t..8t+7.
  localparam logic [0:31][11:0] ROM_TBL = '{
    // tune 0: C5/3, E5/2, G5/1 last
    {1'b0, 4'd1, 7'd3}, {1'b0, 4'd3, 7'd2}, {1'b1, 4'd5, 7'd1}, 12'd0,
    12'd0, 12'd0, 12'd0, 12'd0,
    // tune 1: D5/2, rest/4, F5/1 last
    {1'b0, 4'd2, 7'd2}, {1'b0, 4'd0, 7'd4}, {1'b1, 4'd4, 7'd1}, 12'd0,
    12'd0, 12'd0, 12'd0, 12'd0,
    // tune 2: A5/0 (plays as 1 tick), C6/2 last
    {1'b0, 4'd6, 7'd0}, {1'b1, 4'd8, 7'd2}, 12'd0, 12'd0,
    12'd0, 12'd0, 12'd0, 12'd0,
    // tune 3: rising C5..C6 scale, no last flag
    {1'b0, 4'd1, 7'd1}, {1'b0, 4'd2, 7'd1}, {1'b0, 4'd3, 7'd1}, {1'b0, 4'd4, 7'd1},
    {1'b0, 4'd5, 7'd1}, {1'b0, 4'd6, 7'd1}, {1'b0, 4'd7, 7'd1}, {1'b0, 4'd8, 7'd1}
  };

  function automatic logic [11:0] rom_entry(input logic [1:0] t, input logic [IDXW-1:0] i);
    int unsigned k;
    k = 32'(i);
    rom_entry = '0;
    if (k < 8) rom_entry = ROM_TBL[{t, k[2:0]}];
  endfunction

  function automatic logic [31:0] note_period(input logic [3:0] code);
    case (code)
      4'd1:    note_period = 32'd191113;
      4'd2:    note_period = 32'd170265;
      4'd3:    note_period = 32'd151685;
      4'd4:    note_period = 32'd143172;
      4'd5:    note_period = 32'd127551;
      4'd6:    note_period = 32'd113636;
      4'd7:    note_period = 32'd101239;
      4'd8:    note_period = 32'd95557;
      default: note_period = '0;
    endcase
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NOTE,
    GAP,
    FIN
  } state_t;

  state_t          state, state_next;
  logic [1:0]      tune_q;
  logic [IDXW-1:0] idx;
  logic [31:0]     cyc_cnt;
  logic [31:0]     tick_cnt;
  logic [6:0]      dur_q;
  logic            last_q;

  logic [31:0]     period_q;
  logic            aud_q;
  logic            busy_q;
  logic            done_q;

  logic [11:0]     entry;
  logic [31:0]     entry_period;
  logic            entry_audible;
  logic [31:0]     dur_ticks;
  logic            tick_end;
  logic            note_end;
  logic            gap_end;
  logic            final_note;
  logic            timing_state;

  always_comb begin
    entry         = rom_entry(tune_q, idx);
    entry_period  = note_period(entry[10:7]);
    entry_audible = (entry[10:7] >= 4'd1) && (entry[10:7] <= 4'd8);
    dur_ticks     = (dur_q == '0) ? 32'd1 : {25'd0, dur_q};
    timing_state  = (state == NOTE) || (state == GAP);
    tick_end      = timing_state && (cyc_cnt == TICK_LAST);
    note_end      = tick_end && (tick_cnt == dur_ticks - 32'd1);
    gap_end       = tick_end && (tick_cnt == GAP_LAST);
    final_note    = last_q || (idx == IDX_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.play) state_next = LOAD;
      LOAD: state_next = NOTE;
      NOTE: begin
        if (note_end) begin
          if (GAP_TICKS > 0)   state_next = GAP;
          else if (final_note) state_next = FIN;
          else                 state_next = LOAD;
        end
      end
      GAP:  if (gap_end) state_next = final_note ? FIN : LOAD;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tune_q   <= '0;
      idx      <= '0;
      cyc_cnt  <= '0;
      tick_cnt <= '0;
      dur_q    <= '0;
      last_q   <= 1'b0;
      period_q <= '0;
      aud_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state <= state_next;

      case (state)
        IDLE: begin
          if (bus.play) begin
            tune_q <= bus.tune_sel;
            idx    <= '0;
          end
        end
        LOAD: begin
          dur_q  <= entry[6:0];
          last_q <= entry[11];
          if (entry_audible) period_q <= entry_period;
        end
        NOTE, GAP: begin
          if (state_next == LOAD) idx <= idx + IDXW'(1);
        end
        default: ;
      endcase

      // Counters restart on every state change, so no tick phase carries between notes.
      if (state_next != state || !timing_state || tick_end) cyc_cnt <= '0;
      else                                                  cyc_cnt <= cyc_cnt + 32'd1;

      if (state_next != state || !timing_state) tick_cnt <= '0;
      else if (tick_end)                        tick_cnt <= tick_cnt + 32'd1;

      // Outputs are registered from the next state so they align with the state they describe.
      aud_q  <= (state_next == NOTE) && ((state == LOAD) ? entry_audible : aud_q);
      busy_q <= (state_next != IDLE);
      done_q <= (state_next == FIN);
    end
  end

  assign bus.period = period_q;
  assign bus.audEn  = aud_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
